anton_neopixel_frame_scheduler: RTL and testbench

//  Paces frame output of anton_neopixel_module at a fixed refresh rate and owns the

---
 rtl/anton_neopixel_frame_scheduler.sv | 123 ++++++++++++
 tb/tb_anton_neopixel_frame_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_frame_scheduler.sv
// Frame pacing and double-buffer swap control for the neopixel stream.
// Issues one syncStart per frame slot and guards the stream with a frameDone watchdog.
module anton_neopixel_frame_scheduler #(
    parameter int FRAME_PERIOD  = 106666,
    parameter int TIMEOUT_TICKS = 640000,
    parameter int COUNT_BITS    = 16
) (
    input  logic                  clk6_4mhz,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  swapReq,
    input  logic                  frameDone,
    input  logic                  clearFlags,
    output logic                  syncStart,
    output logic                  bufferSelect,
    output logic                  swapAck,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeoutErr,
    output logic [COUNT_BITS-1:0] frameCount
);

    localparam int PW = $clog2(FRAME_PERIOD);
    localparam int WW = $clog2(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        START  = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] period_cnt;
    logic [WW-1:0] watchdog;
    logic          swap_pending;
    logic          tick;
    logic          wd_expire;
    logic          do_swap;
    logic          overrun_evt;
    logic          timeout_evt;
    logic          frame_done_evt;

    assign tick           = (state != IDLE) && (period_cnt == PW'(FRAME_PERIOD - 1));
    assign wd_expire      = (state == STREAM) && (watchdog == WW'(TIMEOUT_TICKS - 1));
    assign frame_done_evt = (state == STREAM) && frameDone;
    assign overrun_evt    = (state == STREAM) && tick && !frameDone;
    assign timeout_evt    = wd_expire && !frameDone;
    // A swapReq arriving in the very cycle we commit to START still lands in that frame.
    assign do_swap        = (state_nxt == START) && (swap_pending || swapReq);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) state_nxt = ARMED;
            end
            ARMED: begin
                if (!enable)  state_nxt = IDLE;
                else if (tick) state_nxt = START;
            end
            START: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (frameDone) begin
                    if (tick && enable) state_nxt = START;
                    else if (!enable)   state_nxt = IDLE;
                    else                state_nxt = ARMED;
                end else if (wd_expire) begin
                    state_nxt = enable ? ARMED : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk6_4mhz) begin
        if (!rstn) begin
            state        <= IDLE;
            period_cnt   <= '0;
            watchdog     <= '0;
            swap_pending <= 1'b0;
            syncStart    <= 1'b0;
            bufferSelect <= 1'b0;
            swapAck      <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeoutErr   <= 1'b0;
            frameCount   <= '0;
        end else begin
            state <= state_nxt;

            // Slot counter free-runs through START/STREAM so frame spacing never drifts.
            if (state == IDLE || period_cnt == PW'(FRAME_PERIOD - 1))
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + PW'(1);

            if (state == STREAM && state_nxt == STREAM)
                watchdog <= watchdog + WW'(1);
            else
                watchdog <= '0;

            swap_pending <= do_swap ? 1'b0 : (swap_pending | swapReq);
            bufferSelect <= bufferSelect ^ do_swap;
            swapAck      <= do_swap;
            syncStart    <= (state_nxt == START);
            busy         <= (state_nxt == START) || (state_nxt == STREAM);

            if (frame_done_evt)
                frameCount <= frameCount + COUNT_BITS'(1);

            if (overrun_evt)     overrun <= 1'b1;
            else if (clearFlags) overrun <= 1'b0;

            if (timeout_evt)     timeoutErr <= 1'b1;
            else if (clearFlags) timeoutErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// Directed bench for anton_neopixel_frame_scheduler: expected syncStart frames are queued
// by the stimulus and checked by a negedge monitor; flag/counter values are checked inline.
module tb_anton_neopixel_frame_scheduler;

    logic        clk6_4mhz = 1'b0;
    logic        rstn;
    logic        enable;
    logic        swapReq;
    logic        frameDone;
    logic        clearFlags;
    logic        syncStart;
    logic        bufferSelect;
    logic        swapAck;
    logic        busy;
    logic        overrun;
    logic        timeoutErr;
    logic [15:0] frameCount;

    anton_neopixel_frame_scheduler #(
        .FRAME_PERIOD (100),
        .TIMEOUT_TICKS(300),
        .COUNT_BITS   (16)
    ) dut (
        .clk6_4mhz   (clk6_4mhz),
        .rstn        (rstn),
        .enable      (enable),
        .swapReq     (swapReq),
        .frameDone   (frameDone),
        .clearFlags  (clearFlags),
        .syncStart   (syncStart),
        .bufferSelect(bufferSelect),
        .swapAck     (swapAck),
        .busy        (busy),
        .overrun     (overrun),
        .timeoutErr  (timeoutErr),
        .frameCount  (frameCount)
    );

    always #5 clk6_4mhz = ~clk6_4mhz;

    // cyc is the number of the cycle currently in progress; cycle k ends at rising edge k.
    int cyc = 1;
    always @(posedge clk6_4mhz) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int   cyc;
        logic bsel;
        logic ack;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic go(input int k);
        while (cyc < k) begin
            @(posedge clk6_4mhz);
            #1;
        end
    endtask

    task automatic push(input int c, input logic b, input logic a);
        exp_t e;
        e.cyc  = c;
        e.bsel = b;
        e.ack  = a;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, int'({syncStart, bufferSelect, swapAck, busy, overrun, timeoutErr}), 0);
        chk({name, "_cnt"}, int'(frameCount), 0);
    endtask

    always @(negedge clk6_4mhz) begin : monitor
        exp_t e;
        if (syncStart === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL sync_unexpected: syncStart=1 at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("sync_cycle", cyc, e.cyc);
                chk("sync_bsel", int'(bufferSelect), int'(e.bsel));
                chk("sync_ack", int'(swapAck), int'(e.ack));
            end
        end
    end

    initial begin
        rstn = 1'b0; enable = 1'b0; swapReq = 1'b0; frameDone = 1'b0; clearFlags = 1'b0;
        go(2);  chk_zero("reset_c2");
        go(4);  chk_zero("reset_c4");
        rstn = 1'b1; enable = 1'b1;

        // Start and swap: two swapReqs before the first frame fold into one swap.
        push(105, 1'b1, 1'b1);
        push(205, 1'b1, 1'b0);
        go(54);  swapReq = 1'b1;   go(55);  swapReq = 1'b0;
        go(80);  swapReq = 1'b1;   go(81);  swapReq = 1'b0;
        go(110); chk("busy_stream", int'(busy), 1);
        go(125); frameDone = 1'b1; go(126); frameDone = 1'b0;
        go(127); chk("count_1", int'(frameCount), 1);
                 chk("busy_armed", int'(busy), 0);
        go(160); frameDone = 1'b1; go(161); frameDone = 1'b0;
        go(170); chk("done_ignored", int'(frameCount), 1);
        go(225); frameDone = 1'b1; go(226); frameDone = 1'b0;
        go(227); chk("count_2", int'(frameCount), 2);

        // Overrun: frame 305 finishes late, slot at 405 is skipped.
        push(305, 1'b1, 1'b0);
        push(505, 1'b1, 1'b0);
        go(400); chk("ovr_before", int'(overrun), 0);
        go(406); chk("ovr_set", int'(overrun), 1);
                 chk("ovr_busy", int'(busy), 1);
        go(455); frameDone = 1'b1; go(456); frameDone = 1'b0;
        go(457); chk("count_3", int'(frameCount), 3);
        go(470); clearFlags = 1'b1; go(471); clearFlags = 1'b0;
        go(472); chk("ovr_clear", int'(overrun), 0);

        // frameDone on the tick restarts immediately; then a frame that never completes.
        push(605, 1'b1, 1'b0);
        go(604); frameDone = 1'b1; go(605); frameDone = 1'b0;
        go(606); chk("ontime_ovr", int'(overrun), 0);
                 chk("count_4", int'(frameCount), 4);
        go(705); chk("to_ovr", int'(overrun), 1);
        go(905); chk("to_before", int'(timeoutErr), 0);
        go(906); chk("to_set", int'(timeoutErr), 1);
                 chk("to_count", int'(frameCount), 4);
                 chk("to_busy", int'(busy), 0);
        go(950); clearFlags = 1'b1; go(951); clearFlags = 1'b0;
        go(952); chk("clr_ovr", int'(overrun), 0);
                 chk("clr_to", int'(timeoutErr), 0);

        // swapReq in the tick cycle, then enable dropped mid-stream with clear racing a set.
        push(1005, 1'b0, 1'b1);
        go(1004); swapReq = 1'b1;  go(1005); swapReq = 1'b0;
        go(1050); enable = 1'b0;
        go(1104); chk("race_pre", int'(overrun), 0);
                  clearFlags = 1'b1; go(1105); clearFlags = 1'b0;
        go(1106); chk("race_set_wins", int'(overrun), 1);
        go(1120); frameDone = 1'b1; go(1121); frameDone = 1'b0;
        go(1122); chk("count_5", int'(frameCount), 5);
                  chk("idle_busy", int'(busy), 0);

        // Restart, then reset mid-stream with a swap pending.
        push(1301, 1'b1, 1'b1);
        go(1200); enable = 1'b1;
        go(1250); swapReq = 1'b1;  go(1251); swapReq = 1'b0;
        go(1340); swapReq = 1'b1;  go(1341); swapReq = 1'b0;
        go(1349); chk("pre_rst_busy", int'(busy), 1);
        go(1350); rstn = 1'b0; enable = 1'b0;
        go(1351); chk_zero("rst_mid");
        go(1352); rstn = 1'b1;
        push(1461, 1'b0, 1'b0);
        go(1360); enable = 1'b1;
        go(1462); chk("post_rst_count", int'(frameCount), 0);
                  chk("post_rst_busy", int'(busy), 1);
        go(1480); chk("sync_missing", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
